// File: rtl/value_ramp_pkg.sv
// Shared state encoding and step arithmetic for the value ramp driver.
package value_ramp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  // Move cur toward tgt by min(step, |tgt-cur|); never overshoots, never wraps.
  function automatic logic [31:0] step_toward(input logic [31:0] tgt,
                                              input logic [31:0] cur,
                                              input logic [31:0] step);
    logic        up;
    logic [31:0] diff;
    logic [31:0] mag;
    up   = (tgt >= cur);
    diff = up ? (tgt - cur) : (cur - tgt);
    mag  = (diff < step) ? diff : step;
    return up ? (cur + mag) : (cur - mag);
  endfunction

endpackage

// File: rtl/value_ramp_driver_tick_counter.sv
// Hold-interval down-counter: load/reload to HOLD_CYCLES-1, tick when at zero.
module ramp_tick_counter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  output logic tick_c
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CNT_W-1:0] count_q;

  // Clear dominates load; otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(HOLD_CYCLES - 1);
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign tick_c = (count_q == '0);

endmodule

// File: rtl/value_ramp_driver.sv
// Walks data_out toward an accepted target in bounded steps, one step per hold interval.
module value_ramp_driver
  import value_ramp_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] target_in,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             changed,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             changed_q, changed_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             load_c;
  logic             clear_c;
  logic             tick_c;
  logic [WIDTH-1:0] step_val_c;

  // Abort only matters in RAMP, so an IDLE abort cannot cancel a same-cycle accept.
  assign clear_c = rst | ((state_q == ST_RAMP) & abort);

  ramp_tick_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_tick (
    .clk   (clk),
    .clear (clear_c),
    .load  (load_c),
    .tick_c(tick_c)
  );

  assign step_val_c = WIDTH'(step_toward(32'(target_q), 32'(data_q), 32'(STEP)));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      target_q  <= '0;
      changed_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      target_q  <= target_d;
      changed_q <= changed_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    target_d  = target_q;
    changed_d = 1'b0;
    done_d    = 1'b0;
    load_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (target_valid) begin
          target_d = target_in;
          if (target_in == data_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
            load_c  = 1'b1;
          end
        end
      end
      ST_RAMP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          data_d    = step_val_c;
          changed_d = 1'b1;
          load_c    = 1'b1;
          if (step_val_c == target_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RAMP);
  end

  assign target_ready = (state_q == ST_IDLE);
  assign data_out     = data_q;
  assign changed      = changed_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_value_ramp_driver.sv
// Directed vector bench for value_ramp_driver: STEP=3/HOLD=2 and STEP=1/HOLD=1 instances.
module tb_value_ramp_driver;

  typedef struct {
    logic       rst;
    logic       tv;
    logic [7:0] tin;
    logic       ab;
    logic [7:0] e_data;
    logic       e_chg;
    logic       e_done;
    logic       e_busy;
    logic       e_rdy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: STEP=3, HOLD_CYCLES=2
  logic       a_rst, a_tv, a_ab;
  logic [7:0] a_tin, a_data;
  logic       a_rdy, a_chg, a_busy, a_done;
  // Instance B: STEP=1, HOLD_CYCLES=1
  logic       b_rst, b_tv, b_ab;
  logic [7:0] b_tin, b_data;
  logic       b_rdy, b_chg, b_busy, b_done;

  value_ramp_driver #(.WIDTH(8), .STEP(3), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst(a_rst), .target_in(a_tin), .target_valid(a_tv),
    .target_ready(a_rdy), .abort(a_ab), .data_out(a_data),
    .changed(a_chg), .busy(a_busy), .done(a_done)
  );

  value_ramp_driver #(.WIDTH(8), .STEP(1), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(b_rst), .target_in(b_tin), .target_valid(b_tv),
    .target_ready(b_rdy), .abort(b_ab), .data_out(b_data),
    .changed(b_chg), .busy(b_busy), .done(b_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic tv, input logic [7:0] tin,
                              input logic ab, input logic [7:0] d, input logic c,
                              input logic dn, input logic b, input logic r);
    vec_t v;
    v.rst = rst; v.tv = tv; v.tin = tin; v.ab = ab;
    v.e_data = d; v.e_chg = c; v.e_done = dn; v.e_busy = b; v.e_rdy = r;
    return v;
  endfunction

  // Drive one vector before an edge, compare outputs 1 time unit after it.
  task automatic apply(input bit sel_b, input int row, input vec_t v);
    if (!sel_b) begin
      a_rst = v.rst; a_tv = v.tv; a_tin = v.tin; a_ab = v.ab;
    end else begin
      b_rst = v.rst; b_tv = v.tv; b_tin = v.tin; b_ab = v.ab;
    end
    @(posedge clk);
    #1;
    if (!sel_b) begin
      check("a_data", row, 32'(a_data), 32'(v.e_data));
      check("a_changed", row, 32'(a_chg), 32'(v.e_chg));
      check("a_done", row, 32'(a_done), 32'(v.e_done));
      check("a_busy", row, 32'(a_busy), 32'(v.e_busy));
      check("a_ready", row, 32'(a_rdy), 32'(v.e_rdy));
    end else begin
      check("b_data", row, 32'(b_data), 32'(v.e_data));
      check("b_changed", row, 32'(b_chg), 32'(v.e_chg));
      check("b_done", row, 32'(b_done), 32'(v.e_done));
      check("b_busy", row, 32'(b_busy), 32'(v.e_busy));
      check("b_ready", row, 32'(b_rdy), 32'(v.e_rdy));
    end
  endtask

  // Accept a target on instance A and run until done, counting changed pulses.
  task automatic ramp_a(input logic [7:0] tgt, input int exp_chg, input int budget);
    int  nchg;
    bit  seen;
    nchg = 0;
    seen = 1'b0;
    a_tv = 1'b1; a_tin = tgt;
    @(posedge clk);
    #1;
    a_tv = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (a_chg) nchg++;
      if (a_done) seen = 1'b1;
    end
    check("ramp_done_seen", int'(tgt), 32'(seen), 32'(1));
    check("ramp_final_data", int'(tgt), 32'(a_data), 32'(tgt));
    check("ramp_changed_count", int'(tgt), 32'(nchg), 32'(exp_chg));
    check("ramp_ready_after", int'(tgt), 32'(a_rdy), 32'(1));
  endtask

  vec_t va[33];
  vec_t vb[12];

  initial begin
    a_rst = 1'b1; a_tv = 1'b0; a_tin = '0; a_ab = 1'b0;
    b_rst = 1'b1; b_tv = 1'b0; b_tin = '0; b_ab = 1'b0;

    //          rst tv  tin    ab  data   chg dn  bsy rdy
    va[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    va[1]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    va[2]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    va[3]  = mk(0, 1, 8'h07, 0, 8'h00, 0, 0, 1, 0);
    va[4]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    va[5]  = mk(0, 0, 8'h00, 0, 8'h03, 1, 0, 1, 0);
    va[6]  = mk(0, 0, 8'h00, 0, 8'h03, 0, 0, 1, 0);
    va[7]  = mk(0, 0, 8'h00, 0, 8'h06, 1, 0, 1, 0);
    va[8]  = mk(0, 0, 8'h00, 0, 8'h06, 0, 0, 1, 0);
    va[9]  = mk(0, 0, 8'h00, 0, 8'h07, 1, 1, 0, 1);
    va[10] = mk(0, 0, 8'h00, 0, 8'h07, 0, 0, 0, 1);
    va[11] = mk(0, 1, 8'h01, 0, 8'h07, 0, 0, 1, 0);
    va[12] = mk(0, 0, 8'h00, 0, 8'h07, 0, 0, 1, 0);
    va[13] = mk(0, 0, 8'h00, 0, 8'h04, 1, 0, 1, 0);
    va[14] = mk(0, 0, 8'h00, 0, 8'h04, 0, 0, 1, 0);
    va[15] = mk(0, 0, 8'h00, 0, 8'h01, 1, 1, 0, 1);
    va[16] = mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0, 1);
    va[17] = mk(0, 0, 8'h00, 0, 8'h01, 0, 0, 0, 1);
    va[18] = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    va[19] = mk(0, 1, 8'h20, 0, 8'h00, 0, 0, 1, 0);
    va[20] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    va[21] = mk(0, 0, 8'h00, 0, 8'h03, 1, 0, 1, 0);
    va[22] = mk(0, 1, 8'h55, 0, 8'h03, 0, 0, 1, 0);
    va[23] = mk(0, 0, 8'h00, 0, 8'h06, 1, 0, 1, 0);
    va[24] = mk(0, 0, 8'h00, 0, 8'h06, 0, 0, 1, 0);
    va[25] = mk(0, 0, 8'h00, 1, 8'h06, 0, 0, 0, 1);
    va[26] = mk(0, 0, 8'h00, 0, 8'h06, 0, 0, 0, 1);
    va[27] = mk(0, 1, 8'h08, 1, 8'h06, 0, 0, 1, 0);
    va[28] = mk(0, 0, 8'h00, 0, 8'h06, 0, 0, 1, 0);
    va[29] = mk(0, 0, 8'h00, 0, 8'h08, 1, 1, 0, 1);
    va[30] = mk(0, 1, 8'h0A, 0, 8'h08, 0, 0, 1, 0);
    va[31] = mk(0, 0, 8'h00, 0, 8'h08, 0, 0, 1, 0);
    va[32] = mk(0, 0, 8'h00, 0, 8'h0A, 1, 1, 0, 1);

    vb[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    vb[1]  = mk(0, 1, 8'h04, 0, 8'h00, 0, 0, 1, 0);
    vb[2]  = mk(0, 0, 8'h00, 0, 8'h01, 1, 0, 1, 0);
    vb[3]  = mk(0, 0, 8'h00, 0, 8'h02, 1, 0, 1, 0);
    vb[4]  = mk(0, 0, 8'h00, 0, 8'h03, 1, 0, 1, 0);
    vb[5]  = mk(0, 0, 8'h00, 0, 8'h04, 1, 1, 0, 1);
    vb[6]  = mk(0, 0, 8'h00, 0, 8'h04, 0, 0, 0, 1);
    vb[7]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    vb[8]  = mk(0, 1, 8'h04, 0, 8'h00, 0, 0, 1, 0);
    vb[9]  = mk(0, 0, 8'h00, 0, 8'h01, 1, 0, 1, 0);
    vb[10] = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    vb[11] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);

    #2;
    for (int i = 0; i < 33; i++) apply(1'b0, i, va[i]);
    for (int i = 0; i < 12; i++) apply(1'b1, 100 + i, vb[i]);

    // Long ramps on A: up to 0xFE, single clamped step to 0xFF, then down to 0x10.
    a_rst = 1'b1; a_tv = 1'b0; a_ab = 1'b0;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    check("reset_data", 200, 32'(a_data), 32'(0));
    ramp_a(8'hFE, 85, 400);
    ramp_a(8'hFF, 1, 20);
    ramp_a(8'h10, 80, 400);

    // Equal target at 0x10: done next cycle, no changed, never busy.
    a_tv = 1'b1; a_tin = 8'h10;
    @(posedge clk);
    #1;
    a_tv = 1'b0;
    check("eq_done", 300, 32'(a_done), 32'(1));
    check("eq_changed", 300, 32'(a_chg), 32'(0));
    check("eq_busy", 300, 32'(a_busy), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("eq_changed_after", 301 + i, 32'(a_chg), 32'(0));
      check("eq_busy_after", 301 + i, 32'(a_busy), 32'(0));
      check("eq_done_after", 301 + i, 32'(a_done), 32'(0));
      check("eq_data_after", 301 + i, 32'(a_data), 32'(8'h10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
